rc5_key_loader: RTL

- Parametrised successor to the fixed 32-bit/16-byte key-bytes-to-words stage of the RC5 key schedule.
- Converts a B-byte secret key, read one byte per cycle from a synchronous key byte store, into C = ceil(B/U) little-endian W-bit words L[0..C-1].
- Writes each completed word to the L store through a write port, using a start/busy/done handshake.
- Sits between the key byte store and the S/L mixer; runs on a single clock, replacing the clk1/clk2 two-phase scheme.

---
 rtl/rc5_key_loader.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rc5_key_loader.sv
// -----------------------------------------------------------------------------
// rc5_key_loader
//
// Key-bytes-to-words stage of the RC5 key schedule. Reads a B-byte secret key
// one byte per cycle from a synchronous key byte store (highest index first)
// and packs it into C = ceil(B/U) little-endian W-bit words L[0..C-1]. Each
// completed word goes out through the L store write port. L[C-1] is written
// first and L[0] last. Missing top bytes of L[C-1] are zero when B is not a
// multiple of U.
//
// Parameters:
//   W        word width in bits (16, 32 or 64); U = W/8 bytes per word
//   B        key length in bytes (1..255); C = (B+U-1)/U words
//   B_LENGTH key address width
//   C_LENGTH L address width
//
// Ports:
//   clk1        clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   start       start a key expansion (only honoured in IDLE)
//   key_sub_i   key byte, valid one cycle after key_address is driven
//   key_address registered byte index presented to the key store
//   L_we        L store write strobe
//   L_address   L word index (0 whenever L_we is low)
//   L_data      L word value (0 whenever L_we is low)
//   busy        high through all LOAD cycles (and WIPE cycles if enabled)
//   done        one-cycle pulse after the final word write
//
// Optional build macro RC5_KEY_LOADER_ZEROIZE_EN adds:
//   abort       in LOAD, stop reading and zero L[C-1]..L[0], one per cycle
//   aborted     one-cycle pulse after the last zero write (no done pulse)
// -----------------------------------------------------------------------------
module rc5_key_loader #(
   parameter int W        = 32,
   parameter int B        = 16,
   parameter int B_LENGTH = 4,
   parameter int C_LENGTH = 2
) (
   input  logic                clk1,
   input  logic                rst,
   input  logic                start,
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
   input  logic                abort,
   output logic                aborted,
`endif
   input  logic [7:0]          key_sub_i,
   output logic [B_LENGTH-1:0] key_address,
   output logic                L_we,
   output logic [C_LENGTH-1:0] L_address,
   output logic [W-1:0]        L_data,
   output logic                busy,
   output logic                done
);

   localparam int U     = W / 8;
   localparam int C     = (B + U - 1) / U;
   localparam int LOG_U = $clog2(U);
   // Byte index widened so the low LOG_U bits always exist, even for tiny B.
   localparam int KW    = B_LENGTH + 3;

   localparam logic [KW-1:0] U_MASK = KW'(U - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
      ,
      S_WIPE,
      S_ABORT
`endif
   } state_t;

   state_t              state_reg;
   state_t              state_next;

   logic [B_LENGTH-1:0] key_address_reg;
   logic                addr_done_reg;   // address 0 has been issued
   logic [B_LENGTH-1:0] k_d_reg;         // index of the byte now on key_sub_i
   logic                valid_reg;       // key_sub_i carries a requested byte
   logic [W-1:0]        acc_reg;

   logic                abort_req;
   logic [KW-1:0]       kd_wide;
   logic                word_end;
   logic [C_LENGTH-1:0] word_idx;
   logic [W-1:0]        acc_shift;

`ifdef RC5_KEY_LOADER_ZEROIZE_EN
   logic [C_LENGTH-1:0] wipe_idx_reg;
   assign abort_req = abort && (state_reg == S_LOAD);
`else
   assign abort_req = 1'b0;
`endif

   assign kd_wide   = {3'b000, k_d_reg};
   // Byte k closes a word when it is the lowest byte of that word.
   assign word_end  = (kd_wide & U_MASK) == '0;
   assign word_idx  = C_LENGTH'(kd_wide >> LOG_U);
   assign acc_shift = {acc_reg[W-9:0], key_sub_i};

   assign key_address = key_address_reg;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------------------------------------------------- next-state comb
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort_req) begin
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
               state_next = S_WIPE;
`endif
            end else if (valid_reg && (k_d_reg == '0)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
         S_WIPE: begin
            if (wipe_idx_reg == '0) begin
               state_next = S_ABORT;
            end
         end
         S_ABORT: begin
            state_next = S_IDLE;
         end
`endif
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------- datapath
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         key_address_reg <= '0;
         addr_done_reg   <= 1'b0;
         k_d_reg         <= '0;
         valid_reg       <= 1'b0;
         acc_reg         <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               valid_reg <= 1'b0;
               if (start) begin
                  key_address_reg <= B_LENGTH'(B - 1);
                  addr_done_reg   <= 1'b0;
                  acc_reg         <= '0;
               end
            end
            S_LOAD: begin
               if (abort_req) begin
                  // Freeze the address side; no more key bytes are fetched.
                  valid_reg     <= 1'b0;
                  addr_done_reg <= 1'b1;
               end else begin
                  valid_reg <= !addr_done_reg;
                  if (!addr_done_reg) begin
                     k_d_reg <= key_address_reg;
                     if (key_address_reg == '0) begin
                        addr_done_reg <= 1'b1;
                     end else begin
                        key_address_reg <= key_address_reg - 1'b1;
                     end
                  end
                  if (valid_reg) begin
                     acc_reg <= word_end ? '0 : acc_shift;
                  end
               end
            end
            default: begin
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef RC5_KEY_LOADER_ZEROIZE_EN
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         wipe_idx_reg <= '0;
      end else if (abort_req) begin
         wipe_idx_reg <= C_LENGTH'(C - 1);
      end else if (state_reg == S_WIPE) begin
         wipe_idx_reg <= wipe_idx_reg - 1'b1;
      end
   end
`endif

   // ------------------------------------------------------------ output comb
   always_comb begin
      L_we      = 1'b0;
      L_address = '0;
      L_data    = '0;
      busy      = 1'b0;
      done      = 1'b0;
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
      aborted   = 1'b0;
`endif
      case (state_reg)
         S_LOAD: begin
            busy = 1'b1;
            if (valid_reg && word_end && !abort_req) begin
               L_we      = 1'b1;
               L_address = word_idx;
               L_data    = acc_shift;
            end
         end
         S_DONE: begin
            done = 1'b1;
         end
`ifdef RC5_KEY_LOADER_ZEROIZE_EN
         S_WIPE: begin
            busy      = 1'b1;
            L_we      = 1'b1;
            L_address = wipe_idx_reg;
         end
         S_ABORT: begin
            aborted = 1'b1;
         end
`endif
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
